// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: sequential AES SubBytes engine.
// Loads a LENGTH-bit state and substitutes LANES bytes per clock in place,
// using the forward or inverse S-box chosen when the block is accepted.
// valid/ready handshakes are provided on both the input and output sides.
module sub_bytes_seq #(
    parameter int BYTE   = 8,
    parameter int LENGTH = 128,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in,
    input  logic              inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out
);

    localparam int NB    = LENGTH / BYTE;
    localparam int N     = (LANES > 0) ? NB / LANES : 1;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK = LANES * BYTE;
    localparam int LW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    // Only byte-wide S-boxes exist, and the block must split evenly into chunks.
    if (BYTE != 8 || (LENGTH % BYTE) != 0 || LANES < 1 || (NB % LANES) != 0) begin : g_bad_params
        $error("sub_bytes_seq: illegal BYTE/LENGTH/LANES combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_t;

    fsm_t              fsm;
    logic [LENGTH-1:0] state;
    logic              inv_r;
    logic [CW-1:0]     cnt;
    logic [LW-1:0]     chunk_lsb;
    logic [CHUNK-1:0]  chunk;
    logic [CHUNK-1:0]  chunk_sub;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 via a fixed addition chain; maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] y;
        x = ginv(b);
        for (int i = 0; i < 8; i++) begin
            y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
        end
        return y ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        logic [7:0] x;
        for (int i = 0; i < 8; i++) begin
            x[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return ginv(x ^ 8'h05);
    endfunction

    assign chunk_lsb = LW'(cnt * CHUNK);
    assign chunk     = state[chunk_lsb +: CHUNK];
    assign out       = state;

    // One forward/inverse S-box pair per lane; the latched mode picks the result.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [7:0] lane_in;
        logic [7:0] lane_fwd;
        logic [7:0] lane_inv;
        assign lane_in  = chunk[j*BYTE +: BYTE];
        assign lane_fwd = sbox_fwd(lane_in);
        assign lane_inv = sbox_inv(lane_in);
        assign chunk_sub[j*BYTE +: BYTE] = inv_r ? lane_inv : lane_fwd;
    end

    // Control FSM: accept a block, walk the chunks in place, then hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state     <= '0;
            inv_r     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state    <= in;
                        inv_r    <= inv;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        fsm      <= BUSY;
                    end
                end
                BUSY: begin
                    state[chunk_lsb +: CHUNK] <= chunk_sub;
                    if (cnt == CW'(N - 1)) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    fsm       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb_sub_bytes_seq: directed bench for sub_bytes_seq with a table-driven
// reference model checked every cycle, plus literal expectations.
module tb_sub_bytes_seq;

    localparam int NCH = (128 / 8) / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] din = '0;
    logic         inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] dout;

    logic         sw_valid [3];
    logic         sw_ir [3];
    logic         sw_ov [3];
    logic [127:0] sw_out [3];
    logic [127:0] sw_in = '0;
    logic         sw_inv = 1'b0;
    logic         sw_ordy = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    logic [127:0] m_exp = '0;
    int           m_left = 0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;

    sub_bytes_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in(din), .inv(inv), .out_valid(out_valid), .out_ready(out_ready), .out(dout)
    );

    sub_bytes_seq #(.LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[0]), .in_ready(sw_ir[0]),
        .in(sw_in), .inv(sw_inv), .out_valid(sw_ov[0]), .out_ready(sw_ordy), .out(sw_out[0])
    );

    sub_bytes_seq #(.LANES(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[1]), .in_ready(sw_ir[1]),
        .in(sw_in), .inv(sw_inv), .out_valid(sw_ov[1]), .out_ready(sw_ordy), .out(sw_out[1])
    );

    sub_bytes_seq #(.LANES(16)) dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[2]), .in_ready(sw_ir[2]),
        .in(sw_in), .inv(sw_inv), .out_valid(sw_ov[2]), .out_ready(sw_ordy), .out(sw_out[2])
    );

    // Free-running clock.
    initial forever #5 clk = ~clk;

    // Carry-less polynomial product reduced modulo 0x11b.
    function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Build both S-box tables: brute-force inverse, rotation-form affine map,
    // and the inverse table as the permutation inverse of the forward one.
    task automatic buildTables();
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            y = 8'h00;
            if (v != 0) begin
                for (int c = 1; c < 256; c++) begin
                    if (poly_mul(x, 8'(c)) == 8'h01) y = 8'(c);
                end
            end
            s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
            fwd_tab[v] = s;
            inv_tab[s] = x;
        end
    endtask

    function automatic logic [127:0] modelSub(input logic [127:0] blk, input logic m);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[k*8 +: 8] = m ? inv_tab[blk[k*8 +: 8]] : fwd_tab[blk[k*8 +: 8]];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a block is accepted when the engine is free, its result is
    // ready NCH clocks later, and it stays presented until the consumer takes it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else if (!m_busy && !m_done) begin
            if (in_valid) begin
                m_exp  = modelSub(din, inv);
                m_left = NCH;
                m_busy = 1'b1;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (out_ready) begin
            m_done = 1'b0;
        end
    end

    // Compare the default-width DUT against the model every cycle.
    always @(negedge clk) begin
        checkOutput("in_ready", 128'(in_ready), 128'(!m_busy && !m_done));
        checkOutput("out_valid", 128'(out_valid), 128'(m_done));
        if (m_done) checkOutput("out", dout, m_exp);
    end

    task automatic applyStimulus(input logic [127:0] data, input logic m);
        int w;
        @(negedge clk);
        din      = data;
        inv      = m;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w == 50) begin
            n_chk++;
            n_err++;
            $display("[TB] FAIL accept_timeout actual=%0d required<50", w);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat, output logic [127:0] res, input bit toggle);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (toggle) begin
                inv = ~inv;
                din = ~din;
            end
            if (out_valid) break;
        end
        res = dout;
    endtask

    task automatic runSweep(input int idx, input int explat);
        int lat;
        @(negedge clk);
        checkOutput("sweep_in_ready", 128'(sw_ir[idx]), 128'(1));
        sw_valid[idx] = 1'b1;
        @(posedge clk);
        #1 sw_valid[idx] = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (sw_ov[idx]) break;
        end
        checkOutput($sformatf("sweep%0d_latency", idx), 128'(lat), 128'(explat));
        checkOutput($sformatf("sweep%0d_out", idx), sw_out[idx], {16{8'hed}});
    endtask

    initial begin
        int           lat;
        logic [127:0] res;
        logic [127:0] hold;
        for (int i = 0; i < 3; i++) sw_valid[i] = 1'b0;
        buildTables();

        // Pin the model tables to known S-box entries.
        checkOutput("tab_fwd_00", 128'(fwd_tab[8'h00]), 128'h63);
        checkOutput("tab_fwd_53", 128'(fwd_tab[8'h53]), 128'hed);
        checkOutput("tab_fwd_01", 128'(fwd_tab[8'h01]), 128'h7c);
        checkOutput("tab_inv_ed", 128'(inv_tab[8'hed]), 128'h53);

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_out", dout, 128'h0);
        rst_n = 1'b1;

        // Forward block.
        applyStimulus(128'h00112233445566778899aabbccddeeff, 1'b0);
        waitResult(lat, res, 1'b0);
        checkOutput("fwd_latency", 128'(lat), 128'(4));
        checkOutput("fwd_out", res, 128'h638293c31bfc33f5c4eeacea4bc12816);

        // Inverse round trip.
        applyStimulus(res, 1'b1);
        waitResult(lat, res, 1'b0);
        checkOutput("inv_latency", 128'(lat), 128'(4));
        checkOutput("inv_out", res, 128'h00112233445566778899aabbccddeeff);

        // Backpressure, then back-to-back accept on release.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(128'h0123456789abcdeffedcba9876543210, 1'b0);
        waitResult(lat, hold, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_out", dout, hold);
            checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
            checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = {16{8'h53}};
        inv       = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp_release_in_ready", 128'(in_ready), 128'(1));
        checkOutput("bp_release_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        checkOutput("bp_next_accepted", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        waitResult(lat, res, 1'b0);
        checkOutput("bp_next_latency", 128'(lat), 128'(4));
        checkOutput("bp_next_out", res, {16{8'hed}});

        // Reset in the middle of a block.
        applyStimulus(128'hdeadbeef0badf00dcafebabe12345678, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("midrst_out", dout, 128'h0);
        checkOutput("midrst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus({16{8'h01}}, 1'b0);
        waitResult(lat, res, 1'b0);
        checkOutput("postrst_out", res, {16{8'h7c}});

        // Mode and data changes during BUSY must not affect the block.
        applyStimulus(128'h0, 1'b0);
        waitResult(lat, res, 1'b1);
        checkOutput("latch_out", res, {16{8'h63}});
        inv = 1'b0;

        // Lane-count sweep.
        sw_in = {16{8'h53}};
        runSweep(0, 16);
        runSweep(1, 8);
        runSweep(2, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
